// File: rtl/hilo_mdu.sv
// hilo_mdu: HI/LO multiply-divide unit with an iterative restoring divider; define HILO_MADD_EN to enable MADD/MADDU/MSUB/MSUBU
module hilo_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {S_IDLE, S_DIV} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_hi, r_lo, r_quo, r_rem, r_dvs, r_a;
  logic [CW-1:0] r_cnt;
  logic r_qneg, r_rneg, r_dz, r_wr, r_done;
  logic w_mul, w_div, w_mthi, w_mtlo, w_mac, w_sgn, w_acc, w_last, w_pend;
  logic [WIDTH-1:0] w_aa, w_ab, w_q, w_r;
  logic [2*WIDTH-1:0] w_ea, w_eb, w_prod, w_pre, w_mac_v, w_hilo;
  logic [WIDTH:0] w_sh, w_diff;
  assign w_mul  = op == 4'd1 || op == 4'd2;
  assign w_div  = op == 4'd3 || op == 4'd4;
  assign w_mthi = op == 4'd5;
  assign w_mtlo = op == 4'd6;
  assign w_sgn  = op == 4'd1 || op == 4'd3 || op == 4'd7 || op == 4'd9;
  assign busy   = r_state == S_DIV;
  assign done   = r_done;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;
  assign w_acc  = start && !busy && !flush && (w_mul || w_div || w_mthi || w_mtlo || w_mac);
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign w_pend = r_wr && !flush;
  // Sign-extend for signed ops so one 2W-bit multiplier serves both signednesses.
  assign w_ea   = {{WIDTH{w_sgn & a[WIDTH-1]}}, a};
  assign w_eb   = {{WIDTH{w_sgn & b[WIDTH-1]}}, b};
  assign w_prod = w_ea * w_eb;
  assign w_aa   = (w_sgn && a[WIDTH-1]) ? -a : a;
  assign w_ab   = (w_sgn && b[WIDTH-1]) ? -b : b;
  // One restoring step: shift in the next dividend bit and try subtracting the divisor.
  assign w_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff = w_sh - {1'b0, r_dvs};
  // Magnitude result mapped back to signed form; MIN/-1 falls out naturally as MIN rem 0.
  assign w_q    = r_dz ? '1 : r_qneg ? -r_quo : r_quo;
  assign w_r    = r_dz ? r_a : r_rneg ? -r_rem : r_rem;
  // A division result pending this edge lands first, so a same-edge op sees it as prior state.
  assign w_pre  = w_pend ? {w_r, w_q} : {r_hi, r_lo};
`ifdef HILO_MADD_EN
  assign w_mac   = op >= 4'd7 && op <= 4'd10;
  assign w_mac_v = (op == 4'd9 || op == 4'd10) ? w_pre - w_prod : w_pre + w_prod;
`else
  assign w_mac   = 1'b0;
  assign w_mac_v = w_pre;
`endif
  // Next-state and next HI/LO selection.
  always_comb begin
    w_next = r_state;
    if (r_state == S_IDLE && w_acc && w_div) w_next = S_DIV;
    if (r_state == S_DIV && (flush || w_last)) w_next = S_IDLE;
    w_hilo = !w_acc ? w_pre :
             w_mul  ? w_prod :
             w_mthi ? {a, w_pre[WIDTH-1:0]} :
             w_mtlo ? {w_pre[2*WIDTH-1:WIDTH], a} :
             w_mac  ? w_mac_v : w_pre;
  end
  // Control state, HI/LO and done pulse; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_wr    <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state      <= w_next;
      {r_hi, r_lo} <= w_hilo;
      r_done       <= w_pend || (w_acc && !w_div);
      r_wr         <= busy && !flush && w_last;
      r_cnt        <= (w_acc && w_div) ? '0 : busy ? r_cnt + CW'(1) : r_cnt;
    end
  end
  // Divider datapath: latch magnitudes on acceptance, then one quotient bit per busy cycle.
  always_ff @(posedge clk) begin
    if (w_acc && w_div) begin
      r_quo  <= w_aa;
      r_rem  <= '0;
      r_dvs  <= w_ab;
      r_a    <= a;
      r_dz   <= b == '0;
      r_qneg <= w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_rneg <= w_sgn && a[WIDTH-1];
    end else if (busy) begin
      r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
      r_rem <= w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: randomized and directed checks of hilo_mdu against an arithmetic HI/LO model
module tb_hilo_mdu;
  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [3:0] op = '0;
  logic [W-1:0] a = '0, b = '0, hi_o, lo_o;
  logic busy, done;
  int errors = 0, checks = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  always #5 clk = ~clk;
  hilo_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi_o(hi_o), .lo_o(lo_o)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // kind: 0 no effect, 1 immediate write, 2 division
  task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [63:0] nv, output int kind);
    longint sa, sb, q, r;
    logic [63:0] p;
    nv = {m_hi, m_lo};
    kind = 0;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    p = '0;
    case (o)
      4'd1: begin nv = sa * sb; kind = 1; end
      4'd2: begin nv = {32'b0, x} * {32'b0, y}; kind = 1; end
      4'd3, 4'd4: begin
        kind = 2;
        if (y == '0) nv = {x, 32'hFFFF_FFFF};
        else if (o == 4'd3 && x == MIN && y == 32'hFFFF_FFFF) nv = {32'b0, MIN};
        else if (o == 4'd3) begin
          q = sa / sb;
          r = sa % sb;
          nv = {r[31:0], q[31:0]};
        end else nv = {x % y, x / y};
      end
      4'd5: begin nv = {x, m_lo}; kind = 1; end
      4'd6: begin nv = {m_hi, x}; kind = 1; end
`ifdef HILO_MADD_EN
      4'd7, 4'd8, 4'd9, 4'd10: begin
        p = (o == 4'd7 || o == 4'd9) ? sa * sb : {32'b0, x} * {32'b0, y};
        nv = (o >= 4'd9) ? {m_hi, m_lo} - p : {m_hi, m_lo} + p;
        kind = 1;
      end
`endif
      default: kind = 0;
    endcase
  endtask
  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] nv;
    int kind, n;
    model(o, x, y, nv, kind);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (kind == 2) begin
      n = 0;
      while (busy && n < 100) begin
        n++;
        @(negedge clk);
      end
      check({tag, "_busy_cycles"}, n, W);
      check({tag, "_early_done"}, done, 0);
      @(negedge clk);
    end
    check({tag, "_done"}, done, kind != 0);
    check({tag, "_hi"}, hi_o, nv[63:32]);
    check({tag, "_lo"}, lo_o, nv[31:0]);
    m_hi = nv[63:32];
    m_lo = nv[31:0];
  endtask
  task automatic watch_no_done(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) seen++;
    end
    check(tag, seen, 0);
  endtask
  initial begin
    logic [3:0] o;
    logic [W-1:0] x, y;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    rst = 1'b0;
    run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3);
    check("mult_spec", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3);
    check("multu_spec", {hi_o, lo_o}, 64'h0000_0002_FFFF_FFFA);
    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2);
    check("div_spec", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu", 4'd4, 32'd100, 32'd7);
    check("divu_spec", {hi_o, lo_o}, {32'd2, 32'd14});
    run_op("divu0", 4'd4, 32'd5, 32'd0);
    check("divu0_spec", {hi_o, lo_o}, {32'd5, 32'hFFFF_FFFF});
    run_op("divovf", 4'd3, MIN, 32'hFFFF_FFFF);
    check("divovf_spec", {hi_o, lo_o}, {32'd0, MIN});
    // flush mid-division with a refused MTLO while busy
    run_op("clr_hi", 4'd5, 32'd0, 32'd0);
    run_op("clr_lo", 4'd6, 32'd0, 32'd0);
    @(negedge clk);
    op = 4'd4; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op = 4'd6; a = 32'd1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("flush_busy_before", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_hilo", {hi_o, lo_o}, 64'd0);
    check("flush_done", done, 0);
    watch_no_done("flush_no_late_done", W + 4);
    check("flush_mtlo_ignored", lo_o, 0);
    // accumulate ops
    run_op("madd_setlo", 4'd6, 32'd10, 32'd0);
    run_op("madd", 4'd7, 32'd3, 32'd4);
    run_op("msubu", 4'd10, 32'd1, 32'd30);
`ifdef HILO_MADD_EN
    check("msubu_spec", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFF8);
`else
    check("madd_off_spec", {hi_o, lo_o}, {32'd0, 32'd10});
`endif
    // reset in the middle of a division
    run_op("mthi55", 4'd5, 32'd55, 32'd0);
    @(negedge clk);
    op = 4'd4; a = 32'd77; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_hilo", {hi_o, lo_o}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    watch_no_done("midrst_no_done", W + 4);
    run_op("post_rst_multu", 4'd2, 32'd2, 32'd3);
    check("post_rst_spec", {hi_o, lo_o}, 64'd6);
    // random operation mix
    repeat (40) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      case ($urandom_range(0, 4))
        0: y = '0;
        1: y = $urandom_range(1, 20);
        2: begin x = MIN; y = 32'hFFFF_FFFF; end
        default: y = $urandom;
      endcase
      run_op("rnd", o, x, y);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hilo_mdu.md
HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 Parameter WIDTH, default 32, data width of operands and of each HI/LO register (even, >= 8).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; rst, synchronous, active-high.
REQ-004 start  input  1  operation request, sampled on rising edge.
REQ-005 op  input  4  operation code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 NOP.
REQ-006 a  input  WIDTH  operand A (dividend / multiplicand / MTHI/MTLO source).
REQ-007 b  input  WIDTH  operand B (divisor / multiplier).
REQ-008 flush  input  1  pipeline flush; aborts any in-flight division.
REQ-009 busy  output  1  division in progress; new requests refused.
REQ-010 done  output  1  one-cycle pulse: a new HI/LO result is visible this cycle.
REQ-011 hi_o  output  WIDTH  current HI register value.
REQ-012 lo_o  output  WIDTH  current LO register value.

Function
REQ-013 Request accepted on a rising edge iff start=1, busy=0, flush=0, rst=0, and op is not NOP; otherwise it SHALL have no effect.
REQ-014 FSM states IDLE and DIV; IDLE->DIV on accepted DIV/DIVU; DIV->IDLE after WIDTH iteration cycles, on flush, or on rst.
REQ-015 busy SHALL be 1 exactly while in state DIV.
REQ-016 MULT/MULTU: 2*WIDTH-bit signed/unsigned product; HI=upper half, LO=lower half, written on the accepting edge; done=1 in the following cycle.
REQ-017 MTHI writes a to HI only; MTLO writes a to LO only; written on the accepting edge; done=1 in the following cycle.
REQ-018 DIV/DIVU: radix-2 restoring division, one quotient bit per cycle, on operands latched at the accepting edge; LO=quotient, HI=remainder.
REQ-019 Division latency: HI/LO written on the (WIDTH+1)th rising edge after the accepting edge; busy=1 for exactly WIDTH cycles; done=1 in the cycle after the write.
REQ-020 Signed division: truncate toward zero; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-021 Signed overflow (most-negative / -1): LO=most-negative value, HI=0.
REQ-022 Divide by zero (signed or unsigned): LO=all ones, HI=a; same latency as normal division.
REQ-023 flush in DIV: return to IDLE on that edge; HI/LO unchanged; no done pulse.
REQ-024 start while busy=1 SHALL be ignored; the requester holds the request.
REQ-025 HI/LO SHALL change only at the write points of REQ-016..022 and REQ-028, and on reset.

Reset
REQ-026 On rst=1 at a rising edge: FSM->IDLE, HI=0, LO=0, busy=0, done=0; any in-flight division discarded, including mid-iteration.
REQ-027 rst SHALL take priority over flush, start and division completion in the same cycle.

Configuration
REQ-028 Macro HILO_MADD_EN defined: op 7-10 compute {HI,LO} +/- product (MADD/MSUB signed, MADDU/MSUBU unsigned), modulo 2^(2*WIDTH); timing as MULT.
REQ-029 Macro HILO_MADD_EN undefined: op 7-10 treated as NOP; no accumulator adder is synthesised.

Verification (WIDTH=32)
REQ-030 MULT a=FFFFFFFE, b=3 -> HI=FFFFFFFF, LO=FFFFFFFA, done next cycle; MULTU with the same operands -> HI=00000002, LO=FFFFFFFA.
REQ-031 DIV a=FFFFFFF9, b=2 -> busy 32 cycles, then LO=FFFFFFFD, HI=FFFFFFFF, done pulse; DIVU 100/7 -> LO=14, HI=2.
REQ-032 DIVU a=5, b=0 -> LO=FFFFFFFF, HI=5; DIV a=80000000, b=FFFFFFFF -> LO=80000000, HI=0.
REQ-033 DIVU started with HI=LO=0, flush at the 10th busy cycle -> busy=0 next cycle, HI=LO=0, no done; MTLO start during busy -> ignored.
REQ-034 HILO_MADD_EN defined, HI=0, LO=10: MADD 3,4 -> LO=22; then MSUBU 1,30 -> HI=FFFFFFFF, LO=FFFFFFF8. HILO_MADD_EN undefined: same stimulus -> HI/LO unchanged, no done.
REQ-035 rst asserted mid-DIV after MTHI 55 -> HI=LO=0, busy=0 next cycle; no later done; a following MULTU 2,3 -> LO=6 normally.
